// File: rtl/row_regroup_pkg.sv
// Shared types and helpers for the row_regroup slice (bank state, counter sizing).
package row_regroup_pkg;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } bank_state_e;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regroup_bank.sv
// One row bank: gathers a row UNROLL_IN_X elements at a time, then emits it
// UNROLL_OUT_X elements at a time from a read mux over the stored row.
module regroup_bank
  import row_regroup_pkg::*;
#(
  parameter int IN_WIDTH     = 32,
  parameter int IN_X         = 10,
  parameter int UNROLL_IN_X  = 5,
  parameter int UNROLL_OUT_X = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IN_WIDTH-1:0] wr_data [UNROLL_IN_X],
  input  logic                rd_en,
  output bank_state_e         state,
  output logic                wr_last,
  output logic                rd_last,
  output logic [IN_WIDTH-1:0] rd_data [UNROLL_OUT_X]
);

  localparam int ITER_IN  = IN_X / UNROLL_IN_X;
  localparam int ITER_OUT = IN_X / UNROLL_OUT_X;
  localparam int WXW      = cnt_width(ITER_IN);
  localparam int RXW      = cnt_width(ITER_OUT);
  localparam logic [WXW-1:0] WX_LAST = WXW'(ITER_IN - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(ITER_OUT - 1);

  logic [IN_WIDTH-1:0] mem_q [IN_X];
  logic [IN_WIDTH-1:0] mem_d [IN_X];
  logic [WXW-1:0]      wr_x_q, wr_x_d;
  logic [RXW-1:0]      rd_x_q, rd_x_d;
  bank_state_e         state_q, state_d;

  assign state   = state_q;
  assign wr_last = (wr_x_q == WX_LAST);
  assign rd_last = (rd_x_q == RX_LAST);

  // Next-state: chunk write and wr_x advance in FILL, rd_x advance in EMIT.
  always_comb begin
    mem_d   = mem_q;
    wr_x_d  = wr_x_q;
    rd_x_d  = rd_x_q;
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (wr_en) begin
          for (int e = 0; e < IN_X; e++) begin
            mem_d[e] = (wr_x_q == WXW'(e / UNROLL_IN_X)) ? wr_data[e % UNROLL_IN_X] : mem_q[e];
          end
          if (wr_last) begin
            wr_x_d  = '0;
            state_d = EMIT;
          end else begin
            wr_x_d  = wr_x_q + WXW'(1);
            state_d = FILL;
          end
        end else begin
          wr_x_d = wr_x_q;
        end
      end
      EMIT: begin
        if (rd_en) begin
          if (rd_last) begin
            rd_x_d  = '0;
            state_d = FILL;
          end else begin
            rd_x_d  = rd_x_q + RXW'(1);
            state_d = EMIT;
          end
        end else begin
          rd_x_d = rd_x_q;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Read mux: output beat rd_x shows elements rd_x*UNROLL_OUT_X .. +UNROLL_OUT_X-1.
  always_comb begin
    for (int j = 0; j < UNROLL_OUT_X; j++) begin
      rd_data[j] = '0;
    end
    for (int m = 0; m < ITER_OUT; m++) begin
      for (int j = 0; j < UNROLL_OUT_X; j++) begin
        rd_data[j] = (rd_x_q == RXW'(m)) ? mem_q[m * UNROLL_OUT_X + j] : rd_data[j];
      end
    end
  end

  // State registers; reset discards any partially gathered row.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_x_q  <= '0;
      rd_x_q  <= '0;
      state_q <= FILL;
    end else begin
      mem_q   <= mem_d;
      wr_x_q  <= wr_x_d;
      rd_x_q  <= rd_x_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/row_regroup.sv
// Row width regrouping stage. Define ROW_REGROUP_PINGPONG_EN for two banks
// so one row fills while the previous one emits; default is a single bank.
module row_regroup
  import row_regroup_pkg::*;
#(
  parameter int IN_WIDTH     = 32,
  parameter int IN_X         = 10,
  parameter int UNROLL_IN_X  = 5,
  parameter int UNROLL_OUT_X = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] data_in [UNROLL_IN_X],
  input  logic                data_in_valid,
  output logic                data_in_ready,
  output logic [IN_WIDTH-1:0] data_out [UNROLL_OUT_X],
  output logic                data_out_valid,
  input  logic                data_out_ready
);

`ifdef ROW_REGROUP_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  if ((IN_X % UNROLL_IN_X) != 0) begin : g_bad_unroll_in
    $error("row_regroup: UNROLL_IN_X must divide IN_X");
  end
  if ((IN_X % UNROLL_OUT_X) != 0) begin : g_bad_unroll_out
    $error("row_regroup: UNROLL_OUT_X must divide IN_X");
  end

  logic                wb_q, wb_d, rb_q, rb_d;
  logic                in_hs, out_hs, in_row_done, out_row_done;
  bank_state_e         bank_state   [NUM_BANKS];
  logic                bank_wr_last [NUM_BANKS];
  logic                bank_rd_last [NUM_BANKS];
  logic                bank_wr_en   [NUM_BANKS];
  logic                bank_rd_en   [NUM_BANKS];
  logic [IN_WIDTH-1:0] bank_rd_data [NUM_BANKS][UNROLL_OUT_X];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    regroup_bank #(
      .IN_WIDTH    (IN_WIDTH),
      .IN_X        (IN_X),
      .UNROLL_IN_X (UNROLL_IN_X),
      .UNROLL_OUT_X(UNROLL_OUT_X)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (bank_wr_en[b]),
      .wr_data(data_in),
      .rd_en  (bank_rd_en[b]),
      .state  (bank_state[b]),
      .wr_last(bank_wr_last[b]),
      .rd_last(bank_rd_last[b]),
      .rd_data(bank_rd_data[b])
    );
  end

  // Steering: ready comes only from the write bank's state, never from data_out_ready.
  always_comb begin
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    in_row_done    = 1'b0;
    out_row_done   = 1'b0;
    for (int j = 0; j < UNROLL_OUT_X; j++) begin
      data_out[j] = '0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      data_in_ready  = (wb_q == 1'(b)) ? (bank_state[b] == FILL) : data_in_ready;
      data_out_valid = (rb_q == 1'(b)) ? (bank_state[b] == EMIT) : data_out_valid;
      in_row_done    = (wb_q == 1'(b)) ? bank_wr_last[b] : in_row_done;
      out_row_done   = (rb_q == 1'(b)) ? bank_rd_last[b] : out_row_done;
      for (int j = 0; j < UNROLL_OUT_X; j++) begin
        data_out[j] = (rb_q == 1'(b)) ? bank_rd_data[b][j] : data_out[j];
      end
    end
    in_hs  = data_in_valid && data_in_ready;
    out_hs = data_out_valid && data_out_ready;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_wr_en[b] = in_hs && (wb_q == 1'(b));
      bank_rd_en[b] = out_hs && (rb_q == 1'(b));
    end
    wb_d = (NUM_BANKS > 1) ? (wb_q ^ (in_hs && in_row_done)) : 1'b0;
    rb_d = (NUM_BANKS > 1) ? (rb_q ^ (out_hs && out_row_done)) : 1'b0;
  end

  // Bank pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= 1'b0;
      rb_q <= 1'b0;
    end else begin
      wb_q <= wb_d;
      rb_q <= rb_d;
    end
  end

endmodule

// File: doc/row_regroup.md
# row_regroup

Downstream stage of the row-cut path: consumes rows of `IN_X` elements arriving `UNROLL_IN_X` per beat and re-emits each row `UNROLL_OUT_X` elements per beat, in the same element order. It decouples the unroll factor of the cut/extraction stage from the parallelism of the following linear or activation stage. Rows are gathered into bank storage and then read out. An optional second bank overlaps filling and emitting.

## Interface
- `IN_WIDTH`, 32, bit width of one element
- `IN_X`, 10, elements per row
- `UNROLL_IN_X`, 5, elements per input beat; must divide `IN_X`
- `UNROLL_OUT_X`, 2, elements per output beat; must divide `IN_X`
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high; clock `clk`
- `data_in`  in  `IN_WIDTH` x `UNROLL_IN_X` (unpacked)  input element chunk
- `data_in_valid`  in  1  input chunk valid
- `data_in_ready`  out  1  block can accept a chunk
- `data_out`  out  `IN_WIDTH` x `UNROLL_OUT_X` (unpacked)  output element chunk
- `data_out_valid`  out  1  output chunk valid
- `data_out_ready`  in  1  consumer accepts chunk

## Operation
- `ITER_IN = IN_X/UNROLL_IN_X`; `ITER_OUT = IN_X/UNROLL_OUT_X`.
- Divisibility violations raise an elaboration `$error`.
- Counter widths are `max(1,$clog2(ITER))`.
- Element mapping:
  - input beat k, lane i is element `k*UNROLL_IN_X+i`;
  - output beat m, lane j is element `m*UNROLL_OUT_X+j`.
- Each bank has two states, FILL and EMIT.
- FILL:
  - every handshake (`data_in_valid && data_in_ready`) writes the chunk at write counter `wr_x`, then `wr_x++`;
  - the handshake with `wr_x==ITER_IN-1` clears `wr_x` and moves the bank to EMIT.
- EMIT:
  - `data_out_valid=1` and `data_out` shows the chunk at read counter `rd_x`;
  - every output handshake does `rd_x++`;
  - the handshake with `rd_x==ITER_OUT-1` clears `rd_x` and moves the bank to FILL.
- `data_in_ready` is high when the write-target bank is in FILL.
- `data_in_ready` never depends combinationally on `data_out_ready`.
- Input data with `data_in_valid` low is ignored.
- Once `data_out_valid` is asserted, it and `data_out` stay stable until the handshake.
- Reset, including mid-row:
  - all counters go to 0, all banks to FILL, the bank pointers to 0;
  - storage is zeroed and partially gathered rows are discarded;
  - reset values: `data_out_valid=0`, `data_in_ready=1`, `data_out` all zeros.

## Timing
- Latency: the final input handshake of a row at cycle t gives `data_out_valid=1` at t+1, showing elements 0..`UNROLL_OUT_X-1`.
- Output beats are back-to-back while `data_out_ready` is held high.
- Single bank: `data_in_ready` is low from t+1 until the cycle after the last output handshake. Steady-state row period is `ITER_IN+ITER_OUT` cycles.
- Dual bank: steady-state row period is `max(ITER_IN,ITER_OUT)` cycles.
- Simultaneous input and output handshakes in one cycle on different banks are both honoured.
- A bank that finishes EMIT is writable in the next cycle, not the same cycle.

## Configuration
- Macro: `ROW_REGROUP_PINGPONG_EN`.
- Defined:
  - two banks, with write pointer `wb` and read pointer `rb` toggling on the row-complete and row-emitted events;
  - input fills bank `wb` while bank `rb` emits;
  - `data_in_ready` is low only when both banks are in EMIT.
- Undefined:
  - one bank;
  - `data_in_ready` is low for the whole of EMIT.
- The interface and element ordering are identical in both builds.

## Structure
- Package `row_regroup_pkg`:
  - bank state enum `{FILL, EMIT}`;
  - function returning `max(1,$clog2(n))` for counter widths.
- Sub-module `regroup_bank`:
  - contains one bank's storage, state, `wr_x`/`rd_x` counters and read mux;
  - is instantiated once, or twice under the macro.
- Top level holds the bank pointers and the ready/valid steering.

## Test plan
- Defaults, one row:
  - stimulus: input beats {0,1,2,3,4} then {5,6,7,8,9}, `data_out_ready=1`;
  - required: output {0,1},{2,3},{4,5},{6,7},{8,9}, first valid the cycle after beat 2 is accepted.
- Output backpressure:
  - stimulus: `data_out_ready` toggled 1,0,1,0…;
  - required: `data_out` holds while valid and not ready, and the order is unchanged.
- Back-to-back rows 0..9 then 10..19 with `data_out_ready=1`:
  - without the macro: `data_in_ready` is low for 5 cycles between rows;
  - with it: the second row is accepted without stall and both rows are emitted in order.
- Reset after the first input beat:
  - required: no output appears;
  - a following row 20..29 is emitted as {20,21}…{28,29}.
- Reverse ratio, `UNROLL_IN_X=2`, `UNROLL_OUT_X=5`:
  - stimulus: five input beats 0..9;
  - required: output {0..4},{5..9}.
- Bubbles:
  - stimulus: random `data_in_valid` gaps and random `data_out_ready` over 50 rows;
  - required: the scoreboard matches element order exactly.
